// File: rtl/cpu_pkg.sv
// Shared CPU definitions: forwarding/ready-stage constants and the in-flight
// scoreboard entry type used by the operand-hazard scoreboard.
package cpu_pkg;

    localparam int FW_RF    = 0;
    localparam int RDY_ALU  = 1;
    localparam int RDY_LOAD = 2;

    // Entry fields are sized for the widest configuration in use
    // (register address up to 8 bits, up to 31 tracked stages).
    localparam int ENTRY_ADDR_W = 8;
    localparam int ENTRY_RDY_W  = 5;

    typedef struct packed {
        logic                    valid;
        logic                    regwrite;
        logic [ENTRY_ADDR_W-1:0] dest;
        logic [ENTRY_RDY_W-1:0]  ready;
    } sb_entry_t;

    // A ready stage of 0 means "immediately", i.e. the first stage; anything
    // past the last tracked stage is pinned to that stage.
    function automatic logic [ENTRY_RDY_W-1:0] clampReady(
        input logic [ENTRY_RDY_W-1:0] r,
        input int                     depth
    );
        if (r == '0) return ENTRY_RDY_W'(RDY_ALU);
        if (int'(r) > depth) return ENTRY_RDY_W'(depth);
        return r;
    endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle between the ID stage and the operand-hazard scoreboard.
interface fwd_scoreboard_if #(
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2
);
    // Handshake: Issue is the decode slot's valid, Stall is its not-ready.
    // An instruction advances exactly in a cycle with Issue=1, Stall=0 and
    // Flush=0; Stall is only ever raised while Issue=1 and Flush=0.
    logic                     Issue;
    logic                     IssueRegWrite;
    logic [ADDR_W-1:0]        IssueDest;
    logic [SEL_W-1:0]         IssueReadyStage;
    logic [NUM_RD*ADDR_W-1:0] RdAddr;
    logic [NUM_RD-1:0]        RdUsed;
    logic                     Flush;
    logic                     Stall;
    logic [NUM_RD*SEL_W-1:0]  FwSel;
    logic [15:0]              StallCount;

    modport master (
        output Issue, IssueRegWrite, IssueDest, IssueReadyStage,
        output RdAddr, RdUsed, Flush,
        input  Stall, FwSel, StallCount
    );

    modport slave (
        input  Issue, IssueRegWrite, IssueDest, IssueReadyStage,
        input  RdAddr, RdUsed, Flush,
        output Stall, FwSel, StallCount
    );
endinterface

// File: rtl/sb_port_resolve.sv
// Resolves one decode read port against the in-flight entries: either a
// forwarding stage select or a stall when the youngest writer is not ready.
module sb_port_resolve
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2
) (
    input  sb_entry_t         entries [DEPTH],
    input  logic [ADDR_W-1:0] addr,
    input  logic              used,
    output logic [SEL_W-1:0]  sel,
    output logic              stall
);

    logic             hit;
    logic [SEL_W-1:0] hitStage;
    logic [SEL_W-1:0] hitReady;
    logic             lookup;

    // Scan oldest to youngest so the youngest matching writer overwrites.
    always_comb begin
        hit      = 1'b0;
        hitStage = '0;
        hitReady = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (entries[k-1].valid && entries[k-1].regwrite &&
                entries[k-1].dest == ENTRY_ADDR_W'(addr)) begin
                hit      = 1'b1;
                hitStage = SEL_W'(k);
                hitReady = SEL_W'(entries[k-1].ready);
            end
        end
    end

    // Register 0 is hard-wired, so it never needs forwarding or a stall.
    assign lookup = used && (addr != '0) && hit;
    assign stall  = lookup && (hitStage < hitReady);
    assign sel    = (lookup && !stall) ? hitStage : SEL_W'(FW_RF);

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-hazard scoreboard: shifts in-flight destinations through DEPTH
// post-decode stages, resolves every read port and counts stall cycles.
module fwd_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = $clog2(DEPTH + 1)
) (
    input logic             Clock,
    input logic             Reset,
    fwd_scoreboard_if.slave sb
);

    sb_entry_t               entries [DEPTH];
    sb_entry_t               newEntry;
    logic [NUM_RD-1:0]       portStall;
    logic [NUM_RD*SEL_W-1:0] fwSel;
    logic                    stallInt;
    logic                    accept;
    logic [15:0]             stallCount;

    for (genvar p = 0; p < NUM_RD; p++) begin : gPort
        sb_port_resolve #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .SEL_W  (SEL_W)
        ) uResolve (
            .entries (entries),
            .addr    (sb.RdAddr[p*ADDR_W +: ADDR_W]),
            .used    (sb.RdUsed[p]),
            .sel     (fwSel[p*SEL_W +: SEL_W]),
            .stall   (portStall[p])
        );
    end

    assign stallInt = sb.Issue && !sb.Flush && (|portStall);
    assign accept   = sb.Issue && !sb.Flush && !stallInt;

    // Stalled or flushed decode slots become bubbles in stage 1.
    always_comb begin
        newEntry = '0;
        if (accept) begin
            newEntry.valid    = 1'b1;
            newEntry.regwrite = sb.IssueRegWrite;
            newEntry.dest     = ENTRY_ADDR_W'(sb.IssueDest);
            newEntry.ready    = clampReady(ENTRY_RDY_W'(sb.IssueReadyStage), DEPTH);
        end
    end

    // Stages past decode always advance; only the decode slot is held.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries[k] <= '0;
            end
            stallCount <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                entries[k] <= entries[k-1];
            end
            entries[0] <= newEntry;
            if (stallInt && stallCount != 16'hFFFF) begin
                stallCount <= stallCount + 16'd1;
            end
        end
    end

    assign sb.Stall      = stallInt;
    assign sb.FwSel      = fwSel;
    assign sb.StallCount = stallCount;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed and random decode traffic
// against an age-based model, plus a deep instance for counter saturation.
module tb_fwd_scoreboard;
    import cpu_pkg::*;

    localparam int NUM_RD = 2;
    localparam int DEPTH  = 3;
    localparam int ADDR_W = 5;
    localparam int SEL_W  = 2;
    localparam int EXP_W  = 1 + NUM_RD*SEL_W + 16;

    localparam int S_DEPTH = 15;
    localparam int S_SEL_W = 4;

    logic clk;
    logic rst;
    logic rst2;

    fwd_scoreboard_if #(.NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .SEL_W(SEL_W))   bus  ();
    fwd_scoreboard_if #(.NUM_RD(NUM_RD), .ADDR_W(ADDR_W), .SEL_W(S_SEL_W)) bus2 ();

    fwd_scoreboard #(.NUM_RD(NUM_RD), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) dut (
        .Clock (clk),
        .Reset (rst),
        .sb    (bus)
    );

    fwd_scoreboard #(.NUM_RD(NUM_RD), .DEPTH(S_DEPTH), .ADDR_W(ADDR_W), .SEL_W(S_SEL_W)) dut_sat (
        .Clock (clk),
        .Reset (rst2),
        .sb    (bus2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: instructions remembered with the cycle they issued in;
    // an instruction issued in cycle c sits at stage (n - c) during cycle n.
    typedef struct {
        int cyc;
        bit rw;
        int dest;
        int ready;
    } instr_t;

    instr_t          inflight [$];
    int              cycleNo    = 0;
    int              modelCount = 0;
    logic [EXP_W-1:0] exp_q [$];

    function automatic int clampR(input int r);
        if (r < 1) return 1;
        if (r > DEPTH) return DEPTH;
        return r;
    endfunction

    function automatic void modelPort(input int addr, input bit used,
                                      output int sel, output bit st);
        int best;
        int bestReady;
        sel = 0;
        st  = 1'b0;
        best = -1;
        bestReady = 0;
        if (!used || addr == 0) return;
        foreach (inflight[i]) begin
            int age;
            age = cycleNo - inflight[i].cyc;
            if (age >= 1 && age <= DEPTH && inflight[i].rw && inflight[i].dest == addr &&
                (best < 0 || age < best)) begin
                best = age;
                bestReady = inflight[i].ready;
            end
        end
        if (best < 0) return;
        if (best >= bestReady) sel = best;
        else st = 1'b1;
    endfunction

    // Driver: one decode cycle; the expected response is queued for the monitor.
    task automatic drive(input bit issue, input bit rw, input int dest, input int ready,
                         input int a0, input int a1, input bit u0, input bit u1,
                         input bit flush, input bit doRst, input bit check = 1'b1);
        int sel0, sel1;
        bit st0, st1, st;
        logic [NUM_RD*SEL_W-1:0] expFw;
        @(posedge clk);
        #1;
        rst                 = doRst;
        bus.Issue           = issue;
        bus.IssueRegWrite   = rw;
        bus.IssueDest       = ADDR_W'(dest);
        bus.IssueReadyStage = SEL_W'(ready);
        bus.RdAddr          = {ADDR_W'(a1), ADDR_W'(a0)};
        bus.RdUsed          = {u1, u0};
        bus.Flush           = flush;
        modelPort(a0, u0, sel0, st0);
        modelPort(a1, u1, sel1, st1);
        st    = issue && !flush && (st0 || st1);
        expFw = {SEL_W'(sel1), SEL_W'(sel0)};
        if (check) exp_q.push_back({st, expFw, 16'(modelCount)});
        if (doRst) begin
            inflight.delete();
            modelCount = 0;
        end else begin
            if (st && modelCount < 65535) modelCount++;
            if (issue && !st && !flush) inflight.push_back('{cycleNo, rw, dest, clampR(ready)});
        end
        cycleNo++;
        while (inflight.size() > 0 && cycleNo - inflight[0].cyc > DEPTH) void'(inflight.pop_front());
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Scoreboard monitor: compares mid-cycle, away from the active edge.
    initial begin
        logic [EXP_W-1:0] expv;
        logic [EXP_W-1:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                act  = {bus.Stall, bus.FwSel, bus.StallCount};
                checks++;
                if (act !== expv) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t: stall/fwsel/count got %b/%h/%0d, expected %b/%h/%0d",
                             $time, act[EXP_W-1], act[EXP_W-2 -: NUM_RD*SEL_W], act[15:0],
                             expv[EXP_W-1], expv[EXP_W-2 -: NUM_RD*SEL_W], expv[15:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        bus.Issue = 0; bus.IssueRegWrite = 0; bus.IssueDest = '0; bus.IssueReadyStage = '0;
        bus.RdAddr = '0; bus.RdUsed = '0; bus.Flush = 0;
        bus2.Issue = 0; bus2.IssueRegWrite = 0; bus2.IssueDest = '0; bus2.IssueReadyStage = '0;
        bus2.RdAddr = '0; bus2.RdUsed = '0; bus2.Flush = 0;

        // Reset, then reset-state check.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0);
        idle();

        // Load-use: lw r8, then add reading r8 (stall one cycle, then forward 2).
        drive(1, 1, 8, RDY_LOAD, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 12, RDY_ALU, 8, 0, 1, 0, 0, 0);
        drive(1, 1, 12, RDY_ALU, 8, 0, 1, 0, 0, 0);
        idle();
        // Load, independent, consumer: no stall.
        drive(1, 1, 7, RDY_LOAD, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 20, RDY_ALU, 1, 2, 1, 1, 0, 0);
        drive(1, 0, 0, RDY_ALU, 7, 0, 1, 0, 0, 0);
        idle(); idle();

        // ALU chain: both ports on r9, then the writer ages out.
        drive(1, 1, 9, RDY_ALU, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 13, RDY_ALU, 9, 9, 1, 1, 0, 0);
        drive(1, 0, 0, RDY_ALU, 9, 0, 1, 0, 0, 0);
        drive(1, 0, 0, RDY_ALU, 0, 9, 0, 1, 0, 0);
        drive(1, 0, 0, RDY_ALU, 9, 9, 1, 1, 0, 0);

        // Youngest writer wins.
        drive(1, 1, 10, RDY_ALU, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 10, RDY_ALU, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, RDY_ALU, 10, 10, 1, 1, 0, 0);

        // Register 0 never matches.
        drive(1, 1, 0, RDY_LOAD, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, RDY_ALU, 0, 0, 1, 1, 0, 0);
        idle(); idle();

        // Flush during a load-use hazard; the flushed dest (14) never appears.
        drive(1, 1, 11, RDY_LOAD, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 14, RDY_ALU, 11, 0, 1, 0, 1, 0);
        drive(1, 0, 0, RDY_ALU, 14, 14, 1, 1, 0, 0);
        idle(); idle();

        // Reset mid-stall.
        drive(1, 1, 15, RDY_LOAD, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 3, RDY_ALU, 0, 15, 0, 1, 0, 1);
        drive(1, 1, 3, RDY_ALU, 0, 15, 0, 1, 0, 0);

        // Ready stage 0 behaves like an ALU result.
        drive(1, 1, 16, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, RDY_ALU, 16, 0, 1, 0, 0, 0);
        idle(); idle();

        // Random traffic over a small register set to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 7), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end
        idle();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        // Saturation on a deep instance: a chain of ready=15 writers each read
        // by the next gives 14 stall cycles per 15-cycle period.
        @(posedge clk); #1;
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        bus2.Issue = 1; bus2.IssueRegWrite = 1; bus2.IssueDest = ADDR_W'(5);
        bus2.IssueReadyStage = S_SEL_W'(15);
        bus2.RdAddr = {ADDR_W'(0), ADDR_W'(5)}; bus2.RdUsed = 2'b01; bus2.Flush = 0;
        chk("sat_start_count", int'(bus2.StallCount), 0);
        repeat (1500) @(posedge clk);
        #1;
        chk("sat_count_1500", int'(bus2.StallCount), 1400);
        repeat (70215 - 1500) @(posedge clk);
        #1;
        chk("sat_count_pre", int'(bus2.StallCount), 65534);
        @(posedge clk); #1;
        chk("sat_count_accept", int'(bus2.StallCount), 65534);
        chk("sat_stall_now", int'(bus2.Stall), 1);
        @(posedge clk); #1;
        chk("sat_count_max", int'(bus2.StallCount), 65535);
        @(posedge clk); #1;
        chk("sat_count_hold", int'(bus2.StallCount), 65535);
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        chk("sat_reset_count", int'(bus2.StallCount), 0);
        chk("sat_reset_fwsel", int'(bus2.FwSel), 0);
        chk("sat_reset_stall", int'(bus2.Stall), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
